// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter
//
// Round-robin scheduler that shares the FT600 TX ring buffer between up to
// four byte-stream sources. It is the only writer of tx_buf / tx_buf_send.
// Once a source is granted it keeps the grant until its last byte is written.
// With HEADER_EN=1 each packet is prefixed by one header byte (8'hA0 | id),
// which lets the host demultiplex the sources.
//
// Handshake: a source byte transfers on a rising clk edge when
// src_valid[i] && src_ready[i]. src_ready is combinational from the state,
// grant_id and ring-full status only; it never depends on src_valid. src_valid
// may drop mid-packet, and the grant is held until the byte marked src_last
// has transferred.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   src_valid [N]   : per-source byte available
//   src_data  [8N]  : source i drives bits [8i+7:8i]
//   src_last  [N]   : current byte ends the packet
//   src_ready [N]   : byte accepted this cycle when valid && ready
//   tx_buf          : ring storage, slot k is bits [8k+7:8k] (not reset)
//   tx_buf_send     : write pointer, next slot to fill
//   tx_buf_sent     : read pointer from ft600_mode245 (synchronous to clk)
//   grant_id        : index of the granted source
//   busy            : state is not IDLE
//   stalled         : a write was blocked by a full ring last cycle
//   dbg_state       : current FSM state encoding (0 IDLE, 1 HEADER, 2 DATA)

module ft_tx_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int TX_BUF_WIDTH = 8,
  parameter int HEADER_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [8*NUM_SRC-1:0]          src_data,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [(8<<TX_BUF_WIDTH)-1:0]  tx_buf,
  output logic [TX_BUF_WIDTH-1:0]       tx_buf_send,
  input  logic [TX_BUF_WIDTH-1:0]       tx_buf_sent,
  output logic [1:0]                    grant_id,
  output logic                          busy,
  output logic                          stalled,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      grant_q, grant_d;
  logic [1:0]                      last_grant_q, last_grant_d;
  logic [TX_BUF_WIDTH-1:0]         send_q;
  logic [TX_BUF_WIDTH-1:0]         send_plus1;
  logic [(8<<TX_BUF_WIDTH)-1:0]    buf_q;
  logic                            stalled_q, stalled_d;

  logic                            full;
  logic                            wr_en;
  logic [7:0]                      wr_data;

  // Source vectors padded to four entries so a 2-bit grant can index them
  // for any NUM_SRC without out-of-range selects.
  logic [3:0]                      valid_pad;
  logic [3:0]                      last_pad;
  logic [31:0]                     data_pad;

  logic                            pick_found;
  logic [1:0]                      pick_idx;

  assign valid_pad = 4'(src_valid);
  assign last_pad  = 4'(src_last);
  assign data_pad  = 32'(src_data);

  // One slot is always left empty so full and empty are distinguishable.
  assign send_plus1 = send_q + TX_BUF_WIDTH'(1);
  assign full       = (send_plus1 == tx_buf_sent);

  // Round-robin pick: first valid source scanning upward from last_grant+1.
  always_comb begin
    int         cand;
    logic [1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 0;
    cand_idx   = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_SRC;
      cand_idx = 2'(cand);
      if (!pick_found && valid_pad[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state, write strobe and write data.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = (HEADER_EN != 0) ? S_HEADER : S_DATA;
        end
      end
      S_HEADER: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = 8'hA0 | {6'd0, grant_q};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!full && valid_pad[grant_q]) begin
          wr_en   = 1'b1;
          wr_data = data_pad[{grant_q, 3'b000} +: 8];
          if (last_pad[grant_q]) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only the granted source sees ready, and only in DATA with room in the ring.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (state_q == S_DATA) && (grant_q == 2'(i)) && !full;
    end
  end

  // A blocked write counts only when there is actually something to write.
  assign stalled_d = full && ((state_q == S_HEADER) ||
                              ((state_q == S_DATA) && valid_pad[grant_q]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'(NUM_SRC - 1);
      send_q       <= '0;
      stalled_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stalled_q    <= stalled_d;
      if (wr_en) begin
        send_q <= send_plus1;
      end
    end
  end

  // Ring storage carries no reset; a write is suppressed during reset so an
  // abandoned packet cannot leave a stray byte behind.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      buf_q[{send_q, 3'b000} +: 8] <= wr_data;
    end
  end

  assign tx_buf      = buf_q;
  assign tx_buf_send = send_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign stalled     = stalled_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter. Three instances share clk/rst:
//   u_main  : defaults (2 sources, 256-byte ring, headers on)
//   u_full  : 16-byte ring for the full-ring behaviour
//   u_nohdr : headers disabled
// Inputs change #1 after the rising edge; outputs are sampled at that point.

module tb_ft_tx_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- u_main signals ----------------
  logic [1:0]    m_valid, m_last, m_ready, m_gid, m_state;
  logic [15:0]   m_data;
  logic [2047:0] m_buf;
  logic [7:0]    m_send, m_sent;
  logic          m_busy, m_stalled;

  // ---------------- u_full signals ----------------
  logic [1:0]    f_valid, f_last, f_ready, f_gid, f_state;
  logic [15:0]   f_data;
  logic [127:0]  f_buf;
  logic [3:0]    f_send, f_sent;
  logic          f_busy, f_stalled;
  int            f_idx;

  // ---------------- u_nohdr signals ----------------
  logic [1:0]    n_valid, n_last, n_ready, n_gid, n_state;
  logic [15:0]   n_data;
  logic [2047:0] n_buf;
  logic [7:0]    n_send, n_sent;
  logic          n_busy, n_stalled;

  int cyc;

  ft_tx_arbiter #(.NUM_SRC(2), .TX_BUF_WIDTH(8), .HEADER_EN(1)) u_main (
    .clk(clk), .rst(rst),
    .src_valid(m_valid), .src_data(m_data), .src_last(m_last),
    .src_ready(m_ready), .tx_buf(m_buf), .tx_buf_send(m_send),
    .tx_buf_sent(m_sent), .grant_id(m_gid), .busy(m_busy),
    .stalled(m_stalled), .dbg_state(m_state)
  );

  ft_tx_arbiter #(.NUM_SRC(2), .TX_BUF_WIDTH(4), .HEADER_EN(1)) u_full (
    .clk(clk), .rst(rst),
    .src_valid(f_valid), .src_data(f_data), .src_last(f_last),
    .src_ready(f_ready), .tx_buf(f_buf), .tx_buf_send(f_send),
    .tx_buf_sent(f_sent), .grant_id(f_gid), .busy(f_busy),
    .stalled(f_stalled), .dbg_state(f_state)
  );

  ft_tx_arbiter #(.NUM_SRC(2), .TX_BUF_WIDTH(8), .HEADER_EN(0)) u_nohdr (
    .clk(clk), .rst(rst),
    .src_valid(n_valid), .src_data(n_data), .src_last(n_last),
    .src_ready(n_ready), .tx_buf(n_buf), .tx_buf_send(n_send),
    .tx_buf_sent(n_sent), .grant_id(n_gid), .busy(n_busy),
    .stalled(n_stalled), .dbg_state(n_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_valid = '0; m_last = '0; m_data = '0; m_sent = '0;
    f_valid = '0; f_last = '0; f_data = '0; f_sent = '0;
    n_valid = '0; n_last = '0; n_data = '0; n_sent = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  // Source-0 driver for u_full: byte n carries value n, byte 20 is last.
  task automatic f_step();
    logic acc;
    acc = f_valid[0] && f_ready[0];
    tick();
    if (acc) begin
      f_idx++;
      f_data[7:0] = 8'(f_idx);
      f_last[0]   = (f_idx == 20);
    end
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();

    // Reset state
    chk("rst_send",    32'(m_send), 0);
    chk("rst_busy",    32'(m_busy), 0);
    chk("rst_ready",   32'(m_ready), 0);
    chk("rst_stalled", 32'(m_stalled), 0);
    chk("rst_gid",     32'(m_gid), 0);
    chk("rst_f_send",  32'(f_send), 0);
    chk("rst_n_busy",  32'(n_busy), 0);
    rst = 1'b0;

    // Single source: 11,22,33
    m_valid = 2'b01; m_data = 16'h0011; m_last = 2'b00;
    cyc = 0;
    while (!m_ready[0] && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("t1_accept_latency", 32'(cyc), 2);
    tick();
    m_data = 16'h0022;
    tick();
    m_data = 16'h0033; m_last = 2'b01;
    tick();
    m_valid = 2'b00; m_last = 2'b00;
    chk("t1_send",  32'(m_send), 4);
    chk("t1_slot0", 32'(m_buf[0 +: 8]),  32'h A0);
    chk("t1_slot1", 32'(m_buf[8 +: 8]),  32'h 11);
    chk("t1_slot2", 32'(m_buf[16 +: 8]), 32'h 22);
    chk("t1_slot3", 32'(m_buf[24 +: 8]), 32'h 33);
    chk("t1_busy",  32'(m_busy), 0);

    // Round-robin fairness: both sources, 1-byte packets, always valid
    do_reset();
    m_valid = 2'b11; m_last = 2'b11; m_data = 16'h2010;
    tick(); tick(); tick();
    chk("t2_send_3cyc", 32'(m_send), 2);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    m_valid = 2'b00; m_last = 2'b00;
    chk("t2_send_12cyc", 32'(m_send), 8);
    chk("t2_hdr0", 32'(m_buf[0 +: 8]),  32'h A0);
    chk("t2_dat0", 32'(m_buf[8 +: 8]),  32'h 10);
    chk("t2_hdr1", 32'(m_buf[16 +: 8]), 32'h A1);
    chk("t2_dat1", 32'(m_buf[24 +: 8]), 32'h 20);
    chk("t2_hdr2", 32'(m_buf[32 +: 8]), 32'h A0);
    chk("t2_hdr3", 32'(m_buf[48 +: 8]), 32'h A1);

    // Packet lock: source 1 holds the grant while source 0 waits
    do_reset();
    m_valid = 2'b10; m_data = 16'h3100; m_last = 2'b00;
    tick(); tick();
    chk("t3_gid", 32'(m_gid), 1);
    m_valid = 2'b11; m_data = 16'h3177; m_last = 2'b01;
    chk("t3_rdy0_pre", 32'(m_ready[0]), 0);
    tick();
    m_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_rdy0_gap", 32'(m_ready[0]), 0);
      chk("t3_send_gap", 32'(m_send), 2);
    end
    m_valid = 2'b11; m_data = 16'h3277; m_last = 2'b11;
    tick();
    chk("t3_send_last", 32'(m_send), 3);
    tick(); tick(); tick();
    m_valid = 2'b00; m_last = 2'b00;
    chk("t3_slot1", 32'(m_buf[8 +: 8]),  32'h 31);
    chk("t3_slot2", 32'(m_buf[16 +: 8]), 32'h 32);
    chk("t3_slot3", 32'(m_buf[24 +: 8]), 32'h A0);
    chk("t3_slot4", 32'(m_buf[32 +: 8]), 32'h 77);
    chk("t3_send",  32'(m_send), 5);
    chk("t3_stalled", 32'(m_stalled), 0);

    // Full ring (16 slots, read pointer held at 0), 20-byte packet
    f_idx = 1;
    f_valid = 2'b01; f_data = 16'h0001; f_last = 2'b00;
    for (int c = 0; c < 30; c++) f_step();
    chk("t4_send_full", 32'(f_send), 15);
    chk("t4_stalled",   32'(f_stalled), 1);
    chk("t4_ready_off", 32'(f_ready[0]), 0);
    chk("t4_slot0",     32'(f_buf[0 +: 8]),   32'h A0);
    chk("t4_slot1",     32'(f_buf[8 +: 8]),   32'h 01);
    chk("t4_slot14",    32'(f_buf[112 +: 8]), 32'h 0E);
    f_sent = 4'd1;
    f_step();
    chk("t4_send_wrap", 32'(f_send), 0);
    chk("t4_slot15",    32'(f_buf[120 +: 8]), 32'h 0F);
    chk("t4_stalled_clr", 32'(f_stalled), 0);
    f_step();
    f_step();
    chk("t4_send_one_more", 32'(f_send), 0);
    chk("t4_stalled_again", 32'(f_stalled), 1);

    // Reset mid-packet
    m_valid = 2'b01; m_data = 16'h0055; m_last = 2'b00;
    tick(); tick(); tick();
    chk("t5_busy_mid", 32'(m_busy), 1);
    chk("t5_send_mid", 32'(m_send), 7);
    rst = 1'b1;
    tick();
    chk("t5_rst_send",    32'(m_send), 0);
    chk("t5_rst_busy",    32'(m_busy), 0);
    chk("t5_rst_ready",   32'(m_ready), 0);
    chk("t5_rst_stalled", 32'(m_stalled), 0);
    rst = 1'b0;
    m_valid = 2'b11; m_data = 16'h6644; m_last = 2'b11;
    tick();
    chk("t5_gid", 32'(m_gid), 0);
    tick(); tick();
    m_valid = 2'b00; m_last = 2'b00;
    chk("t5_slot0", 32'(m_buf[0 +: 8]), 32'h A0);
    chk("t5_slot1", 32'(m_buf[8 +: 8]), 32'h 44);
    chk("t5_send",  32'(m_send), 2);

    // Header disabled: source 1 sends 5A,5B
    n_valid = 2'b10; n_data = 16'h5A00; n_last = 2'b00;
    cyc = 0;
    while (!n_ready[1] && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("t6_accept_latency", 32'(cyc), 1);
    tick();
    n_data = 16'h5B00; n_last = 2'b10;
    tick();
    n_valid = 2'b00; n_last = 2'b00;
    chk("t6_slot0", 32'(n_buf[0 +: 8]), 32'h 5A);
    chk("t6_slot1", 32'(n_buf[8 +: 8]), 32'h 5B);
    chk("t6_send",  32'(n_send), 2);
    chk("t6_busy",  32'(n_busy), 0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
